multdiv_seq_ctrl: RTL and testbench
===================================

// Module: multdiv_seq_ctrl
// PURPOSE
//   Iterative signed 32-bit multiply/divide unit with its sequencing FSM. Runs a radix-2
//   shift-add multiply (partial product = multiplicand AND-gated by current multiplier bit)
//   or a restoring divide, one bit per clock. Sits beside the ALU in execute. The pipeline
//   stalls on busy and picks up data_result on data_resultRDY.
// PARAMETERS
//   WIDTH   32   operand/result width; iteration count = WIDTH; only 32 is verified
// PORTS
//   clock           in   1      single clock, rising-edge
//   reset_n         in   1      asynchronous, active-low reset
//   ctrl_MULT       in   1      start signed multiply; sampled on clock edge
//   ctrl_DIV        in   1      start signed divide; sampled on clock edge
//   data_operandA   in   32     multiplicand / dividend; captured at start edge only
//   data_operandB   in   32     multiplier / divisor; captured at start edge only
//   data_result     out  32     low 32 bits of product, or quotient
//   data_exception  out  1      overflow / divide-by-zero flag for data_result
//   data_resultRDY  out  1      one-cycle pulse: data_result/data_exception valid
//   busy            out  1      high while an operation is iterating
// BEHAVIOUR
//   Reset (reset_n=0, any time incl. mid-op): state=IDLE, counter=0. All datapath regs 0.
//     data_result=0, data_exception=0, data_resultRDY=0, busy=0. Op in flight is discarded.
//   FSM states: IDLE, MULT, DIV, DONE.
//     IDLE/DONE + ctrl_MULT -> MULT. IDLE/DONE + ctrl_DIV (ctrl_MULT=0) -> DIV.
//     Both asserted on one edge: MULT wins; ctrl_DIV is dropped.
//     MULT/DIV: counter increments each edge; after WIDTH iterations -> DONE.
//     DONE: remains until next start; a start from DONE is accepted with no idle gap.
//   Start edge E0: operands captured as magnitudes. sign = A[31]^B[31]. counter=0. busy=1 from E0.
//   Iteration edges E1..E32: one bit per edge (MULT: add (|A| AND {32{mplr[0]}}) into
//     64-bit acc, shift; DIV: shift remainder, trial-subtract |B|, set quotient bit).
//   Edge E32 (counter==WIDTH-1): result sign-corrected and registered. Exception
//     computed. state=DONE. busy=0 and data_resultRDY=1 from E32 to E33.
//     Latency: ctrl at E0 -> RDY visible after E32, i.e. 32 cycles.
//   data_resultRDY high exactly one cycle per accepted op. data_result/data_exception
//     hold until the next op's E32; not cleared at start.
//   Start while busy=1: ignored. In-flight op and its result are unaffected.
//     Operand changes after E0 have no effect.
//   Multiply: two's complement. data_result = low 32 bits of the signed 64-bit product.
//     data_exception=1 iff the 64-bit product is not the sign-extension of bits[31:0].
//   Divide: signed quotient, truncates toward zero; remainder discarded.
//     Divisor 0: data_result=0, data_exception=1, full 32-cycle latency.
//     0x80000000 / 0xFFFFFFFF: data_result=0x80000000, data_exception=1.
//   Magnitude of 0x80000000 is held as unsigned 33-bit-safe; no internal overflow.
// TESTING
//   ctrl_MULT, A=7, B=-3 -> RDY pulse exactly 32 cycles after start; result=0xFFFFFFEB; exc=0.
//   ctrl_MULT, A=0x00010000, B=0x00010000 -> result=0x00000000, exc=1.
//     A=0x80000000, B=1 -> result=0x80000000, exc=0.
//   ctrl_DIV, A=-7, B=2 -> result=0xFFFFFFFD; exc=0. A=5, B=0 -> result=0, exc=1.
//     A=0x80000000, B=-1 -> result=0x80000000, exc=1.
//   Start op with A=3, B=4. At cycle 10 pulse ctrl_DIV with new operands -> ignored.
//     RDY at cycle 32, result=12, exactly one RDY pulse.
//   ctrl_MULT and ctrl_DIV together, A=6, B=3 -> result=18. Back-to-back: start in DONE
//     cycle -> second RDY 32 cycles later.
//   Drop reset_n at cycle 15 of a multiply -> busy, RDY, result, exc = 0 immediately.
//     After release, a new op completes normally with no stale RDY.

Source files
------------

// File: rtl/multdiv_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_seq_ctrl_if
//  Purpose  : Start/operand/result bundle between the execute stage and the
//             iterative multiply/divide unit.
//  Signals  : ctrl_MULT, ctrl_DIV        start strobes (pipeline -> unit)
//             data_operandA/B            operands, captured on the start edge
//             data_result/exception      result and its overflow/div0 flag
//             data_resultRDY             one-cycle result-valid pulse
//             busy                       high while the unit is iterating
//  Modports : master (pipeline side), slave (multdiv unit side)
//  Revision : 1.0  initial release
// ============================================================================
interface multdiv_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface
`default_nettype wire

// File: rtl/multdiv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_seq_ctrl
//  Purpose  : Iterative signed multiply (radix-2 shift-add) / restoring divide,
//             one bit per clock, WIDTH iterations per operation.
//  Ports    : clock    rising-edge clock
//             reset_n  asynchronous active-low reset
//             bus      multdiv_seq_ctrl_if.slave (start, operands, result,
//                      exception, resultRDY, busy)
//  Notes    : Operands are converted to magnitudes on the start edge; the sign
//             is reapplied on the last iteration edge together with the
//             exception computation. Starts while busy are ignored.
//  Revision : 1.0  initial release
// ============================================================================
module multdiv_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    multdiv_seq_ctrl_if.slave  bus
);

    localparam int c_CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_count;

    // r_mag holds the operand that stays constant during iteration:
    // |A| (multiplicand) for multiply, |B| (divisor) for divide.
    logic [WIDTH-1:0]     r_mag;
    // Multiply: {partial product high half, remaining multiplier bits}.
    // Divide  : low half is the dividend shifting out / quotient shifting in.
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_rem;
    logic                 r_sign;
    logic                 r_div_zero;

    logic [WIDTH-1:0]     r_result;
    logic                 r_exc;
    logic                 r_rdy;

    logic                 w_busy;
    logic                 w_start;
    logic                 w_last;

    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
        // The most negative value maps onto itself, which is its correct
        // unsigned magnitude.
        f_abs = v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    // ------------------------------------------------------------------
    // Single-iteration datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_rem_shift;
    logic [WIDTH:0]       w_trial;
    logic                 w_fit;
    logic [WIDTH-1:0]     w_rem_next;
    logic [WIDTH-1:0]     w_quo_next;

    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                       + {1'b0, r_mag & {WIDTH{r_acc[0]}}};
    assign w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Remainder stays below |B| <= 2^(WIDTH-1), so the shifted value fits in
    // WIDTH+1 bits and the trial sign bit is a clean borrow indicator.
    assign w_rem_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_trial     = w_rem_shift - {1'b0, r_mag};
    assign w_fit       = ~w_trial[WIDTH];
    assign w_rem_next  = w_fit ? w_trial[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
    assign w_quo_next  = {r_acc[WIDTH-2:0], w_fit};

    // ------------------------------------------------------------------
    // Final sign correction and exception detection
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0]   w_prod_s;
    logic                 w_mul_exc;
    logic [WIDTH-1:0]     w_quo_s;
    logic [WIDTH-1:0]     w_div_res;
    logic                 w_div_exc;

    assign w_prod_s  = r_sign ? (~w_mul_next + 1'b1) : w_mul_next;
    assign w_mul_exc = (w_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_s[WIDTH-1]}});

    assign w_quo_s   = r_sign ? (~w_quo_next + 1'b1) : w_quo_next;
    assign w_div_res = r_div_zero ? '0 : w_quo_s;
    // A positive quotient with the top bit set (only MIN / -1) cannot be
    // represented; a negative one of magnitude 2^(WIDTH-1) can.
    assign w_div_exc = r_div_zero | (~r_sign & w_quo_next[WIDTH-1]);

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_start      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.ctrl_MULT) begin
                    w_state_next = S_MULT;
                    w_start      = 1'b1;
                end else if (bus.ctrl_DIV) begin
                    w_state_next = S_DIV;
                    w_start      = 1'b1;
                end
            end
            S_MULT, S_DIV: begin
                w_busy = 1'b1;
                if (r_count == c_CNT_W'(WIDTH - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_mag      <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_sign     <= 1'b0;
            r_div_zero <= 1'b0;
            r_result   <= '0;
            r_exc      <= 1'b0;
            r_rdy      <= 1'b0;
        end else begin
            r_rdy <= w_last;
            if (w_start) begin
                r_count    <= '0;
                r_rem      <= '0;
                r_sign     <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                if (bus.ctrl_MULT) begin
                    r_mag      <= f_abs(bus.data_operandA);
                    r_acc      <= {{WIDTH{1'b0}}, f_abs(bus.data_operandB)};
                    r_div_zero <= 1'b0;
                end else begin
                    r_mag      <= f_abs(bus.data_operandB);
                    r_acc      <= {{WIDTH{1'b0}}, f_abs(bus.data_operandA)};
                    r_div_zero <= (bus.data_operandB == '0);
                end
            end else if (w_busy) begin
                r_count <= w_last ? '0 : r_count + 1'b1;
                if (r_state == S_MULT) begin
                    r_acc <= w_mul_next;
                    if (w_last) begin
                        r_result <= w_prod_s[WIDTH-1:0];
                        r_exc    <= w_mul_exc;
                    end
                end else begin
                    r_acc <= {r_acc[2*WIDTH-1:WIDTH], w_quo_next};
                    r_rem <= w_rem_next;
                    if (w_last) begin
                        r_result <= w_div_res;
                        r_exc    <= w_div_exc;
                    end
                end
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
    assign bus.busy           = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multdiv_seq_ctrl
//  Purpose  : Directed self-checking bench for multdiv_seq_ctrl. An
//             arithmetic reference model tracks expected outputs every cycle;
//             each directed operation also carries a hand-computed result.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multdiv_seq_ctrl;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    always #5 clock = ~clock;

    multdiv_seq_ctrl_if #(.WIDTH(32)) bus ();

    multdiv_seq_ctrl #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks    = 0;
    int failures  = 0;
    int rdy_total = 0;
    int ops_done  = 0;
    bit cmp_en    = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: full-precision signed result, then truncate.
    function automatic void calc(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
        longint sa;
        longint sb;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_mult && b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
            return;
        end
        p = is_mult ? sa * sb : sa / sb;
        r = p[31:0];
        e = (p != longint'($signed(r)));
    endfunction

    // Cycle-level model: an accepted start produces its result 32 edges later.
    logic        m_busy   = 1'b0;
    logic        m_rdy    = 1'b0;
    logic [31:0] m_res    = 32'd0;
    logic        m_exc    = 1'b0;
    logic [31:0] pend_res = 32'd0;
    logic        pend_exc = 1'b0;
    int          m_left   = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0;
            m_rdy  = 1'b0;
            m_res  = 32'd0;
            m_exc  = 1'b0;
            m_left = 0;
        end else begin
            m_rdy = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_rdy  = 1'b1;
                    m_busy = 1'b0;
                    m_res  = pend_res;
                    m_exc  = pend_exc;
                end
            end else if (bus.ctrl_MULT || bus.ctrl_DIV) begin
                calc(bus.ctrl_MULT, bus.data_operandA, bus.data_operandB, pend_res, pend_exc);
                m_left = 32;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        #1;
        if (cmp_en) begin
            check1 ("cyc_busy",   bus.busy,           m_busy);
            check1 ("cyc_rdy",    bus.data_resultRDY, m_rdy);
            check32("cyc_result", bus.data_result,    m_res);
            check1 ("cyc_exc",    bus.data_exception, m_exc);
            if (bus.data_resultRDY) rdy_total++;
        end
    end

    // Issue one operation, then wait (bounded) for its RDY pulse.
    task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee, input int glitch, input string name);
        int n;
        bit got;
        @(negedge clock);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clock);
            #1;
            n++;
            if (n == glitch) begin
                bus.ctrl_DIV      = 1'b1;
                bus.data_operandA = 32'd100;
                bus.data_operandB = 32'd7;
            end else if (glitch != 0 && n == glitch + 1) begin
                bus.ctrl_DIV = 1'b0;
            end
            if (bus.data_resultRDY) got = 1'b1;
        end
        ops_done++;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_timeout actual=no_rdy required=rdy_within_40 t=%0t", name, $time);
        end else if (n != 32) begin
            failures++;
            $display("FAIL %s_latency actual=%0d required=32", name, n);
        end
        check32({name, "_result"}, bus.data_result,    er);
        check1 ({name, "_exc"},    bus.data_exception, ee);
    endtask

    initial begin
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check1 ("rst_busy",   bus.busy,           1'b0);
        check1 ("rst_rdy",    bus.data_resultRDY, 1'b0);
        check32("rst_result", bus.data_result,    32'd0);
        check1 ("rst_exc",    bus.data_exception, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        repeat (2) @(posedge clock);

        //     mult  div  A             B             result        exc
        run_op(1'b1, 1'b0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 0,  "mul_7_m3");
        run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 0,  "mul_ovf");
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0, 0,  "mul_min_1");
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 0,  "mul_min_min");
        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0,  "mul_m1_m1");
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, 0,  "div_m7_2");
        run_op(1'b0, 1'b1, 32'd5,        32'd0,        32'h0000_0000, 1'b1, 0,  "div_by0");
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0,  "div_min_m1");
        run_op(1'b0, 1'b1, 32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 0,  "div_100_m7");
        run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,       1'b0, 0,  "div_m100_m7");
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0, 0,  "div_min_1");
        run_op(1'b0, 1'b1, 32'd7,        32'h8000_0000, 32'd0,        1'b0, 0,  "div_7_min");
        run_op(1'b1, 1'b0, 32'd3,        32'd4,        32'd12,       1'b0, 10, "mul_glitch");
        run_op(1'b1, 1'b1, 32'd6,        32'd3,        32'd18,       1'b0, 0,  "both_start");
        run_op(1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30,       1'b0, 0,  "mul_m5_m6");

        // Abort a multiply mid-flight with reset.
        @(negedge clock);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'h0000_1234;
        bus.data_operandB = 32'h0000_0010;
        @(posedge clock);
        #1 bus.ctrl_MULT = 1'b0;
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check1 ("abort_busy",   bus.busy,           1'b0);
        check1 ("abort_rdy",    bus.data_resultRDY, 1'b0);
        check32("abort_result", bus.data_result,    32'd0);
        check1 ("abort_exc",    bus.data_exception, 1'b0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(posedge clock);

        run_op(1'b0, 1'b1, 32'd1000, 32'd10, 32'd100, 1'b0, 0, "div_after_rst");
        repeat (3) @(posedge clock);
        #2;

        checks++;
        if (rdy_total != ops_done) begin
            failures++;
            $display("FAIL rdy_pulse_count actual=%0d required=%0d", rdy_total, ops_done);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
